ps2_host_tx: RTL and testbench



---
 rtl/ps2_host_tx_if.sv | 23 ++
 rtl/ps2_host_tx.sv | 143 ++++++++++++++
 tb/tb_ps2_host_tx.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_host_tx_if.sv
// PS/2 host transmitter bus: command handshake, pin levels,
// open-drain enables and completion status.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       kclk_in;
  logic       kdata_in;
  logic       kclk_oe;
  logic       kdata_oe;
  logic       done;
  logic [1:0] status;

  modport master (
    output tx_data, tx_valid, kclk_in, kdata_in,
    input  tx_ready, kclk_oe, kdata_oe, done, status
  );

  modport slave (
    input  tx_data, tx_valid, kclk_in, kdata_in,
    output tx_ready, kclk_oe, kdata_oe, done, status
  );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, frame shift
// on device clock falls, ACK check and timeout reporting.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 1500000,
  parameter int FILTER_LEN     = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  ps2_host_tx_if.slave  bus
);
  localparam int CMAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                        INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 2);
  localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, RTS, SEND, ACK_WAIT, RELEASE, DONE
  } state_e;

  // index 0 = kclk, index 1 = kdata
  logic [1:0]         s1_q, s2_q, f_q;
  logic [1:0][FW-1:0] fc_q;
  logic               fprev_q;
  logic               kclk_fall;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [9:0]    sr_q;
  logic [3:0]    nbit_q;
  logic          kclk_oe_q, kdata_oe_q, done_q, ready_q;
  logic [1:0]    status_q;
  logic          tmo;

  assign kclk_fall = fprev_q & ~f_q[0];
  assign tmo       = (cnt_q == TO_LAST);

  assign bus.tx_ready = ready_q;
  assign bus.kclk_oe  = kclk_oe_q;
  assign bus.kdata_oe = kdata_oe_q;
  assign bus.done     = done_q;
  assign bus.status   = status_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= '1;
      s2_q    <= '1;
      f_q     <= '1;
      fc_q    <= '0;
      fprev_q <= 1'b1;
    end else begin
      s1_q    <= {bus.kdata_in, bus.kclk_in};
      s2_q    <= s1_q;
      fprev_q <= f_q[0];
      for (int i = 0; i < 2; i++) begin
        if (s2_q[i] != f_q[i]) begin
          if (fc_q[i] == FLT_LAST) begin
            f_q[i]  <= s2_q[i];
            fc_q[i] <= '0;
          end else begin
            fc_q[i] <= fc_q[i] + 1'b1;
          end
        end else begin
          fc_q[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sr_q       <= '1;
      nbit_q     <= '0;
      kclk_oe_q  <= 1'b0;
      kdata_oe_q <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b1;
      status_q   <= 2'b00;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.tx_valid) begin
            sr_q      <= {1'b1, ~^bus.tx_data, bus.tx_data};
            cnt_q     <= '0;
            nbit_q    <= '0;
            kclk_oe_q <= 1'b1;
            ready_q   <= 1'b0;
            state_q   <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (cnt_q == INH_LAST) begin
            kdata_oe_q <= 1'b1;
            state_q    <= RTS;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RTS: begin
          kclk_oe_q <= 1'b0;
          cnt_q     <= '0;
          state_q   <= SEND;
        end
        SEND, ACK_WAIT, RELEASE: begin
          cnt_q <= cnt_q + 1'b1;
          if (tmo) begin
            kclk_oe_q  <= 1'b0;
            kdata_oe_q <= 1'b0;
            status_q   <= 2'b10;
            done_q     <= 1'b1;
            state_q    <= DONE;
          end else if (state_q == SEND) begin
            if (kclk_fall) begin
              kdata_oe_q <= ~sr_q[0];
              sr_q       <= {1'b1, sr_q[9:1]};
              nbit_q     <= nbit_q + 1'b1;
              if (nbit_q == 4'd9) state_q <= ACK_WAIT;
            end
          end else if (state_q == ACK_WAIT) begin
            if (kclk_fall) begin
              status_q <= {1'b0, f_q[1]};
              state_q  <= RELEASE;
            end
          end else if (&f_q) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: behavioural PS/2 device model with
// randomized command bytes and ACK behaviour.
module tb_ps2_host_tx;
  localparam int INH = 50;
  localparam int FL  = 4;
  localparam int TO  = 20000;
  localparam int H   = 30;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ps2_host_tx_if bus ();

  logic dev_clk = 1'b0;
  logic dev_data = 1'b0;
  logic dev_glitch = 1'b0;

  assign bus.kclk_in  = ~(bus.kclk_oe | dev_clk | dev_glitch);
  assign bus.kdata_in = ~(bus.kdata_oe | dev_data);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO),
    .FILTER_LEN(FL)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_done = 0;
  int n_inh = 0;
  int n_rts = 0;
  int rts_cyc = 0;
  int done_cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (bus.done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (bus.kclk_oe && !bus.kdata_oe) n_inh++;
    if (bus.kclk_oe && bus.kdata_oe) begin
      n_rts++;
      rts_cyc = cyc;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [10:0] ref_frame(input logic [7:0] d);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, d, 1'b0};
  endfunction

  task automatic start_tx(input logic [7:0] d);
    int t;
    t = 0;
    while (!bus.tx_ready && t < 100) begin
      tick();
      t++;
    end
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    tick();
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'($urandom);
  endtask

  task automatic device(input bit ack, input int nclk,
                        input bit glitch,
                        output logic [10:0] bits, output bit ok);
    int t;
    ok = 1'b1;
    bits = '1;
    t = 0;
    while (!bus.kclk_oe && t < 200) begin
      tick();
      t++;
    end
    t = 0;
    while (bus.kclk_oe && t < INH + 200) begin
      tick();
      t++;
    end
    if (t >= INH + 200) ok = 1'b0;
    repeat (H) tick();
    bits[0] = bus.kdata_in;
    for (int i = 1; i <= 10; i++) begin
      if (i <= nclk) begin
        dev_clk = 1'b1;
        repeat (H) tick();
        dev_clk = 1'b0;
        bits[i] = bus.kdata_in;
        if (glitch && i == 3) begin
          repeat (10) tick();
          dev_glitch = 1'b1;
          repeat (2) tick();
          dev_glitch = 1'b0;
          repeat (H - 12) tick();
        end else begin
          repeat (H) tick();
        end
      end
    end
    if (nclk >= 11) begin
      dev_data = ack;
      repeat (H / 2) tick();
      dev_clk = 1'b1;
      repeat (H) tick();
      dev_clk = 1'b0;
      repeat (H / 2) tick();
      dev_data = 1'b0;
    end
  endtask

  task automatic wait_done(input int budget, output bit got,
                           output logic [1:0] st);
    got = 1'b0;
    st = 2'bxx;
    for (int i = 0; i < budget && !got; i++) begin
      tick();
      if (bus.done) begin
        got = 1'b1;
        st = bus.status;
      end
    end
  endtask

  task automatic busy_poke();
    repeat (150) tick();
    n_chk++;
    if (bus.tx_ready !== 1'b0) begin
      $display("FAIL busy_ready: got %b want 0", bus.tx_ready);
      n_fail++;
    end
    bus.tx_data  = 8'h5A;
    bus.tx_valid = 1'b1;
    tick();
    bus.tx_valid = 1'b0;
  endtask

  task automatic test_frame(input logic [7:0] d, input bit ack,
                            input bit glitch);
    int d0, i0, r0;
    logic [10:0] bits, exp;
    logic [1:0] st, exp_st;
    bit ok, got;
    d0 = n_done;
    i0 = n_inh;
    r0 = n_rts;
    exp = ref_frame(d);
    exp_st = ack ? 2'b00 : 2'b01;
    start_tx(d);
    fork
      device(ack, 11, glitch, bits, ok);
      wait_done(3000, got, st);
      if (glitch) busy_poke();
    join
    n_chk++;
    if (!ok || !got) begin
      $display("FAIL frame_%02h_handshake: rts %0b done %0b want 1 1",
               d, ok, got);
      n_fail++;
    end
    n_chk++;
    if (bits !== exp) begin
      $display("FAIL frame_%02h_bits: got %b want %b", d, bits, exp);
      n_fail++;
    end
    n_chk++;
    if (st !== exp_st) begin
      $display("FAIL frame_%02h_status: got %b want %b", d, st, exp_st);
      n_fail++;
    end
    n_chk++;
    if (n_inh - i0 != INH) begin
      $display("FAIL frame_%02h_inhibit: got %0d want %0d",
               d, n_inh - i0, INH);
      n_fail++;
    end
    n_chk++;
    if (n_rts - r0 != 1) begin
      $display("FAIL frame_%02h_rts: got %0d want 1", d, n_rts - r0);
      n_fail++;
    end
    repeat (3) tick();
    n_chk++;
    if (n_done - d0 != 1) begin
      $display("FAIL frame_%02h_done_pulses: got %0d want 1",
               d, n_done - d0);
      n_fail++;
    end
    n_chk++;
    if ({bus.tx_ready, bus.kclk_oe, bus.kdata_oe} !== 3'b100) begin
      $display("FAIL frame_%02h_idle: got rdy/kclk/kdata %b want 100",
               d, {bus.tx_ready, bus.kclk_oe, bus.kdata_oe});
      n_fail++;
    end
  endtask

  task automatic test_reset();
    tick();
    n_chk++;
    if ({bus.tx_ready, bus.kclk_oe, bus.kdata_oe, bus.done} !== 4'b1000)
    begin
      $display("FAIL reset_outputs: got %b want 1000",
               {bus.tx_ready, bus.kclk_oe, bus.kdata_oe, bus.done});
      n_fail++;
    end
    n_chk++;
    if (bus.status !== 2'b00) begin
      $display("FAIL reset_status: got %b want 00", bus.status);
      n_fail++;
    end
    rst_n = 1'b1;
    repeat (3) tick();
    n_chk++;
    if ({bus.tx_ready, bus.kclk_oe, bus.done} !== 3'b100) begin
      $display("FAIL reset_idle: got %b want 100",
               {bus.tx_ready, bus.kclk_oe, bus.done});
      n_fail++;
    end
  endtask

  task automatic test_timeout();
    bit got;
    logic [1:0] st;
    int d0;
    d0 = n_done;
    start_tx(8'hA5);
    wait_done(TO + 500, got, st);
    n_chk++;
    if (!got || st !== 2'b10) begin
      $display("FAIL timeout_status: done %0b status %b want 1 10",
               got, st);
      n_fail++;
    end
    n_chk++;
    if (done_cyc - rts_cyc != TO) begin
      $display("FAIL timeout_latency: got %0d want %0d",
               done_cyc - rts_cyc, TO);
      n_fail++;
    end
    n_chk++;
    if ({bus.kclk_oe, bus.kdata_oe} !== 2'b00) begin
      $display("FAIL timeout_release: got %b want 00",
               {bus.kclk_oe, bus.kdata_oe});
      n_fail++;
    end
    tick();
    n_chk++;
    if ({bus.tx_ready, bus.kclk_oe, bus.kdata_oe, bus.done} !== 4'b1000)
    begin
      $display("FAIL timeout_idle: got %b want 1000",
               {bus.tx_ready, bus.kclk_oe, bus.kdata_oe, bus.done});
      n_fail++;
    end
    n_chk++;
    if (n_done - d0 != 1) begin
      $display("FAIL timeout_pulses: got %0d want 1", n_done - d0);
      n_fail++;
    end
  endtask

  task automatic test_reset_mid();
    logic [10:0] bits;
    bit ok;
    int d0;
    d0 = n_done;
    start_tx(8'h00);
    device(1'b1, 4, 1'b0, bits, ok);
    n_chk++;
    if (!ok || bus.kdata_oe !== 1'b1) begin
      $display("FAIL rstmid_pre: rts %0b kdata_oe %b want 1 1",
               ok, bus.kdata_oe);
      n_fail++;
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({bus.kclk_oe, bus.kdata_oe} !== 2'b00) begin
      $display("FAIL rstmid_async: got %b want 00",
               {bus.kclk_oe, bus.kdata_oe});
      n_fail++;
    end
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (20) tick();
    n_chk++;
    if (n_done != d0) begin
      $display("FAIL rstmid_no_done: got %0d want 0", n_done - d0);
      n_fail++;
    end
    test_frame(8'hF4, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    logic [7:0] d;
    bit ack;
    for (int k = 0; k < 4; k++) begin
      d = 8'($urandom_range(0, 255));
      ack = 1'($urandom_range(0, 1));
      test_frame(d, ack, 1'b0);
      tick();
    end
  endtask

  initial begin
    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;
    test_reset();
    test_frame(8'hED, 1'b1, 1'b0);
    test_frame(8'h00, 1'b1, 1'b0);
    test_frame(8'hFF, 1'b1, 1'b0);
    test_frame(8'h3C, 1'b0, 1'b0);
    test_timeout();
    test_reset_mid();
    test_frame(8'hA7, 1'b1, 1'b1);
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
